// File: rtl/led_rotate_ctrl_if.sv
// Command channel for the LED rotation sequencer.
// Master drives valid/payload, slave returns cmd_ready.
interface led_rotate_ctrl_if #(
    parameter int WIDTH = 12,
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_pattern;
    logic             cmd_dir;
    logic             cmd_mode;
    logic [3:0]       cmd_steps;
    logic [DIV_W-1:0] cmd_div;

    modport master (
        output cmd_valid,
        output cmd_pattern,
        output cmd_dir,
        output cmd_mode,
        output cmd_steps,
        output cmd_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pattern,
        input  cmd_dir,
        input  cmd_mode,
        input  cmd_steps,
        input  cmd_div,
        output cmd_ready
    );
endinterface

// File: rtl/led_rotate_ctrl.sv
// Command-driven LED rotator: loads a pattern, then rotates it left/right
// or bounces at a programmable step rate, with pause and abort.
// Ports: clk, rst (sync, active-high), cmd (command channel, slave side),
//   pause, abort in; led, busy, step_pulse, done out (all registered).
module led_rotate_ctrl #(
    parameter int               WIDTH        = 12,
    parameter logic [WIDTH-1:0] BASE_PATTERN = 12'b000011101101,
    parameter int               DIV_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    led_rotate_ctrl_if.slave  cmd,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  led,
    output logic              busy,
    output logic              step_pulse,
    output logic              done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic [3:0]       steps_q, steps_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic [3:0]       cnt_inc;
    logic [3:0]       leg_len;
    logic [WIDTH-1:0] led_rot;

    assign cnt_inc = cnt_q + 4'd1;
    // A bounce leg of zero steps would never turn around, so it counts as one.
    assign leg_len = (steps_q == 4'd0) ? 4'd1 : steps_q;
    assign led_rot = dir_q ? {led_q[0], led_q[WIDTH-1:1]}
                           : {led_q[WIDTH-2:0], led_q[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        steps_d = steps_q;
        div_d   = div_q;
        if (state_q == IDLE) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (cmd.cmd_valid && ready_q) begin
                dir_d   = cmd.cmd_dir;
                mode_d  = cmd.cmd_mode;
                steps_d = cmd.cmd_steps;
                div_d   = cmd.cmd_div;
                led_d   = cmd.cmd_pattern;
                pre_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
                ready_d = 1'b0;
                busy_d  = 1'b1;
            end
        end else if (abort) begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
        end else if (!pause) begin
            if (pre_q == div_q) begin
                step_d = 1'b1;
                pre_d  = '0;
                cnt_d  = cnt_inc;
                led_d  = led_rot;
                if (mode_q) begin
                    if (cnt_inc == leg_len) begin
                        cnt_d = '0;
                        dir_d = ~dir_q;
                    end
                end else if (steps_q != 4'd0 && cnt_inc == steps_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            led_q   <= BASE_PATTERN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            steps_q <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            steps_q <= steps_d;
            div_q   <= div_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign led           = led_q;
    assign busy          = busy_q;
    assign step_pulse    = step_q;
    assign done          = done_q;
endmodule

// File: tb/tb_led_rotate_ctrl.sv
// Directed self-checking bench for led_rotate_ctrl.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_led_rotate_ctrl;
    localparam logic [11:0] BASE = 12'b000011101101;

    logic        clk;
    logic        rst;
    logic        pause;
    logic        abort;
    logic [11:0] led;
    logic        busy;
    logic        step_pulse;
    logic        done;

    int n_chk;
    int n_fail;

    led_rotate_ctrl_if #(.WIDTH(12), .DIV_W(16)) cmd_bus ();

    led_rotate_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_bus),
        .pause      (pause),
        .abort      (abort),
        .led        (led),
        .busy       (busy),
        .step_pulse (step_pulse),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one edge; the controller is idle, so it is taken.
    task automatic send_cmd(input logic [11:0] pat, input logic dir,
                            input logic mode, input logic [3:0] steps,
                            input logic [15:0] div);
        cmd_bus.cmd_valid   = 1'b1;
        cmd_bus.cmd_pattern = pat;
        cmd_bus.cmd_dir     = dir;
        cmd_bus.cmd_mode    = mode;
        cmd_bus.cmd_steps   = steps;
        cmd_bus.cmd_div     = div;
        tick();
        cmd_bus.cmd_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if (led !== BASE) begin
            n_fail++;
            $display("FAIL reset_led got %b want %b", led, BASE);
        end
        n_chk++;
        if ({cmd_bus.cmd_ready, busy, done, step_pulse} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags got rdy%b busy%b done%b step%b want 1000",
                     cmd_bus.cmd_ready, busy, done, step_pulse);
        end
    endtask

    task automatic test_rotate_left();
        logic [11:0] exp_led [3];
        exp_led[0] = 12'b000111011010;
        exp_led[1] = 12'b001110110100;
        exp_led[2] = 12'b011101101000;
        send_cmd(BASE, 1'b0, 1'b0, 4'd3, 16'd0);
        n_chk++;
        if (led !== BASE || busy !== 1'b1 || cmd_bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL left_accept got led %b busy %b rdy %b want %b 1 0",
                     led, busy, cmd_bus.cmd_ready, BASE);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (led !== exp_led[i] || step_pulse !== 1'b1 ||
                done !== (i == 2)) begin
                n_fail++;
                $display("FAIL left_step%0d got led %b step %b done %b want %b 1 %b",
                         i, led, step_pulse, done, exp_led[i], (i == 2));
            end
        end
        n_chk++;
        if (cmd_bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL left_end got rdy %b busy %b want 1 0",
                     cmd_bus.cmd_ready, busy);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || step_pulse !== 1'b0 || led !== exp_led[2]) begin
            n_fail++;
            $display("FAIL left_after got done %b step %b led %b want 0 0 %b",
                     done, step_pulse, led, exp_led[2]);
        end
    endtask

    task automatic test_rotate_right_div();
        logic [11:0] exp_led;
        send_cmd(BASE, 1'b1, 1'b0, 4'd2, 16'd4);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c < 5)       exp_led = BASE;
            else if (c < 10) exp_led = 12'b100001110110;
            else             exp_led = 12'b010000111011;
            n_chk++;
            if (led !== exp_led || step_pulse !== (c == 5 || c == 10) ||
                done !== (c == 10)) begin
                n_fail++;
                $display("FAIL right_c%0d got led %b step %b done %b want %b %b %b",
                         c, led, step_pulse, done, exp_led,
                         (c == 5 || c == 10), (c == 10));
            end
        end
        n_chk++;
        if (busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL right_end got busy %b rdy %b want 0 1",
                     busy, cmd_bus.cmd_ready);
        end
    endtask

    task automatic test_bounce();
        logic [11:0] seq [8];
        seq[0] = 12'h002; seq[1] = 12'h004; seq[2] = 12'h002; seq[3] = 12'h001;
        seq[4] = 12'h002; seq[5] = 12'h004; seq[6] = 12'h002; seq[7] = 12'h001;
        send_cmd(12'h001, 1'b0, 1'b1, 4'd2, 16'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (led !== seq[i] || step_pulse !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_%0d got led %h step %b done %b want %h 1 0",
                         i, led, step_pulse, done, seq[i]);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1 || led !== 12'h001 ||
            step_pulse !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_abort got busy %b rdy %b led %h step %b done %b want 0 1 001 0 0",
                     busy, cmd_bus.cmd_ready, led, step_pulse, done);
        end
    endtask

    task automatic test_pause_abort();
        send_cmd(BASE, 1'b0, 1'b0, 4'd0, 16'd1);
        tick();
        n_chk++;
        if (led !== BASE || step_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL pa_wait got led %b step %b want %b 0", led, step_pulse, BASE);
        end
        tick();
        n_chk++;
        if (led !== 12'h1DA || step_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL pa_step1 got led %h step %b want 1da 1", led, step_pulse);
        end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (led !== 12'h1DA || step_pulse !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL pa_hold%0d got led %h step %b busy %b want 1da 0 1",
                         i, led, step_pulse, busy);
            end
        end
        pause = 1'b0;
        tick();
        n_chk++;
        if (led !== 12'h1DA || step_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL pa_resume got led %h step %b want 1da 0", led, step_pulse);
        end
        tick();
        n_chk++;
        if (led !== 12'h3B4 || step_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL pa_step2 got led %h step %b want 3b4 1", led, step_pulse);
        end
        tick();
        // The next edge is a due step; abort must win over it.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (led !== 12'h3B4 || step_pulse !== 1'b0 || done !== 1'b0 ||
            busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pa_abort got led %h step %b done %b busy %b rdy %b want 3b4 0 0 0 1",
                     led, step_pulse, done, busy, cmd_bus.cmd_ready);
        end
        tick();
        n_chk++;
        if (led !== 12'h3B4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pa_idle got led %h busy %b want 3b4 0", led, busy);
        end
    endtask

    task automatic test_reset_midrun();
        send_cmd(12'h001, 1'b0, 1'b0, 4'd0, 16'd0);
        tick();
        tick();
        n_chk++;
        if (led !== 12'h004) begin
            n_fail++;
            $display("FAIL rm_run got led %h want 004", led);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (led !== BASE || cmd_bus.cmd_ready !== 1'b1 || busy !== 1'b0 ||
            step_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_reset got led %b rdy %b busy %b step %b want %b 1 0 0",
                     led, cmd_bus.cmd_ready, busy, step_pulse, BASE);
        end
        // Abort while idle must not block a same-cycle command.
        abort = 1'b1;
        send_cmd(12'hABC, 1'b1, 1'b0, 4'd0, 16'd7);
        abort = 1'b0;
        n_chk++;
        if (led !== 12'hABC || busy !== 1'b1 || cmd_bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_accept got led %h busy %b rdy %b want abc 1 0",
                     led, busy, cmd_bus.cmd_ready);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || led !== 12'hABC) begin
            n_fail++;
            $display("FAIL rm_abort got busy %b led %h want 0 abc", busy, led);
        end
    endtask

    initial begin
        n_chk               = 0;
        n_fail              = 0;
        rst                 = 1'b1;
        pause               = 1'b0;
        abort               = 1'b0;
        cmd_bus.cmd_valid   = 1'b0;
        cmd_bus.cmd_pattern = '0;
        cmd_bus.cmd_dir     = 1'b0;
        cmd_bus.cmd_mode    = 1'b0;
        cmd_bus.cmd_steps   = '0;
        cmd_bus.cmd_div     = '0;
        #1;
        test_reset();
        test_rotate_left();
        test_rotate_right_div();
        test_bounce();
        test_pause_abort();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
